// File: rtl/result_bcd_conv.sv
// 8-bit result to 3-digit BCD converter (double dabble); RESULT_SIGNED_EN selects two's-complement input.
// Latency: out_valid rises 8 edges after accept; one conversion per 10 cycles with out_ready held high.
// Backpressure: in_ready only in IDLE; digits hold in DONE until out_valid && out_ready.
module result_bcd_conv (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] out_hund,
    output logic [3:0] out_tens,
    output logic [3:0] out_ones,
    output logic       out_neg,
    output logic       out_valid,
    input  logic       out_ready
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  sr_q, sr_d;
    logic [11:0] bcd_q, bcd_d;
    logic [11:0] bcd_adj;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  mag;
`ifdef RESULT_SIGNED_EN
    logic        neg_q, neg_d;
`endif

    always_comb begin
`ifdef RESULT_SIGNED_EN
        mag   = in_data[7] ? (8'd0 - in_data) : in_data;
        neg_d = neg_q;
`else
        mag   = in_data;
`endif
        bcd_adj[3:0]  = (bcd_q[3:0]  >= 4'd5) ? bcd_q[3:0]  + 4'd3 : bcd_q[3:0];
        bcd_adj[7:4]  = (bcd_q[7:4]  >= 4'd5) ? bcd_q[7:4]  + 4'd3 : bcd_q[7:4];
        bcd_adj[11:8] = (bcd_q[11:8] >= 4'd5) ? bcd_q[11:8] + 4'd3 : bcd_q[11:8];

        state_d     = state_q;
        sr_d        = sr_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        hund_d      = hund_q;
        tens_d      = tens_q;
        ones_d      = ones_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sr_d       = mag;
                    bcd_d      = 12'd0;
                    cnt_d      = 4'd0;
                    in_ready_d = 1'b0;
                    state_d    = SHIFT;
`ifdef RESULT_SIGNED_EN
                    neg_d      = in_data[7];
`endif
                end
            end
            SHIFT: begin
                bcd_d = {bcd_adj[10:0], sr_q[7]};
                sr_d  = {sr_q[6:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                // The eighth shift lands directly in the output digit registers.
                if (cnt_q == 4'd7) begin
                    hund_d      = bcd_d[11:8];
                    tens_d      = bcd_d[7:4];
                    ones_d      = bcd_d[3:0];
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sr_q        <= 8'd0;
            bcd_q       <= 12'd0;
            cnt_q       <= 4'd0;
            hund_q      <= 4'd0;
            tens_q      <= 4'd0;
            ones_q      <= 4'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef RESULT_SIGNED_EN
            neg_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            hund_q      <= hund_d;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef RESULT_SIGNED_EN
            neg_q       <= neg_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_hund  = hund_q;
    assign out_tens  = tens_q;
    assign out_ones  = ones_q;
`ifdef RESULT_SIGNED_EN
    assign out_neg   = neg_q;
`else
    assign out_neg   = 1'b0;
`endif

endmodule
